// File: rtl/timer_pkg.sv
// Shared encodings for the MM:SS timer: run states, BCD digit and MM:SS value types.
// The VGA painter imports the same state encoding to decode actualState.
package timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } timer_state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t m_dec;
      bcd_t m_unit;
      bcd_t s_dec;
      bcd_t s_unit;
   } mmss_t;

   localparam mmss_t MMSS_ZERO = '0;

   // Up-count terminal value: max_min:59.
   function automatic mmss_t mmss_max(input int max_min);
      mmss_t v;
      v.m_dec  = bcd_t'(max_min / 10);
      v.m_unit = bcd_t'(max_min % 10);
      v.s_dec  = 4'd5;
      v.s_unit = 4'd9;
      return v;
   endfunction

endpackage

// File: rtl/bcd_timer_core_if.sv
// Button inputs and display outputs of the timer core, shared with its driver and the VGA painter.
interface bcd_timer_core_if;
   logic       start;
   logic       stop;
   logic       delete;
   logic       incrementSeconds;
   logic       incrementMinutes;
   logic       mode_down;
   logic [3:0] mDecimal;
   logic [3:0] mUnit;
   logic [3:0] sDecimal;
   logic [3:0] sUnit;
   logic [2:0] actualState;
   logic       running;
   logic       finish;
   logic       alarm;

   modport master (
      output start, stop, delete, incrementSeconds, incrementMinutes, mode_down,
      input  mDecimal, mUnit, sDecimal, sUnit, actualState, running, finish, alarm
   );

   modport slave (
      input  start, stop, delete, incrementSeconds, incrementMinutes, mode_down,
      output mDecimal, mUnit, sDecimal, sUnit, actualState, running, finish, alarm
   );
endinterface

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD MM:SS register with edit increments and up/down ticking with carry/borrow.
// is_zero/is_max describe the value being loaded this cycle, so the FSM can react in the same edge.
module bcd_mmss_counter
   import timer_pkg::*;
#(
   parameter int MAX_MIN = 99
) (
   input  logic  CLK_50MHZ,
   input  logic  reset,
   input  logic  load_zero,
   input  logic  inc_sec,
   input  logic  inc_min,
   input  logic  tick_up,
   input  logic  tick_down,
   output mmss_t value,
   output logic  is_zero,
   output logic  is_max
);

   localparam mmss_t TOP = mmss_max(MAX_MIN);

   mmss_t value_reg;
   mmss_t value_next;

   function automatic mmss_t sec_up(input mmss_t v);
      mmss_t r;
      r = v;
      if (v.s_unit == 4'd9) begin
         r.s_unit = 4'd0;
         r.s_dec  = (v.s_dec == 4'd5) ? 4'd0 : v.s_dec + 4'd1;
      end else begin
         r.s_unit = v.s_unit + 4'd1;
      end
      return r;
   endfunction

   function automatic mmss_t sec_down(input mmss_t v);
      mmss_t r;
      r = v;
      if (v.s_unit == 4'd0) begin
         r.s_unit = 4'd9;
         r.s_dec  = (v.s_dec == 4'd0) ? 4'd5 : v.s_dec - 4'd1;
      end else begin
         r.s_unit = v.s_unit - 4'd1;
      end
      return r;
   endfunction

   function automatic mmss_t min_up(input mmss_t v);
      mmss_t r;
      r = v;
      if (v.m_dec == TOP.m_dec && v.m_unit == TOP.m_unit) begin
         r.m_dec  = 4'd0;
         r.m_unit = 4'd0;
      end else if (v.m_unit == 4'd9) begin
         r.m_unit = 4'd0;
         r.m_dec  = v.m_dec + 4'd1;
      end else begin
         r.m_unit = v.m_unit + 4'd1;
      end
      return r;
   endfunction

   // Borrow out of 00 minutes wraps to the top of the range.
   function automatic mmss_t min_down(input mmss_t v);
      mmss_t r;
      r = v;
      if (v.m_dec == 4'd0 && v.m_unit == 4'd0) begin
         r.m_dec  = TOP.m_dec;
         r.m_unit = TOP.m_unit;
      end else if (v.m_unit == 4'd0) begin
         r.m_unit = 4'd9;
         r.m_dec  = v.m_dec - 4'd1;
      end else begin
         r.m_unit = v.m_unit - 4'd1;
      end
      return r;
   endfunction

   always_comb begin
      value_next = value_reg;
      if (load_zero) begin
         value_next = MMSS_ZERO;
      end else if (tick_down) begin
         value_next = sec_down(value_reg);
         if (value_reg.s_dec == 4'd0 && value_reg.s_unit == 4'd0)
            value_next = min_down(value_next);
      end else if (tick_up) begin
         value_next = sec_up(value_reg);
         if (value_reg.s_dec == 4'd5 && value_reg.s_unit == 4'd9)
            value_next = min_up(value_next);
      end else begin
         if (inc_sec)
            value_next = sec_up(value_next);
         if (inc_min)
            value_next = min_up(value_next);
      end
   end

   always_ff @(posedge CLK_50MHZ) begin
      if (reset)
         value_reg <= MMSS_ZERO;
      else
         value_reg <= value_next;
   end

   assign value   = value_reg;
   assign is_zero = (value_next == MMSS_ZERO);
   assign is_max  = (value_next == TOP);

endmodule

// File: rtl/bcd_timer_core.sv
// MM:SS timer core: button edge detection, run-control FSM, 1 Hz prescaler and timed alarm
// around a BCD MM:SS counter.
module bcd_timer_core
   import timer_pkg::*;
#(
   parameter int CLK_DIV      = 50_000_000,
   parameter int MAX_MIN      = 99,
   parameter int ALARM_CYCLES = 100_000_000
) (
   input logic             CLK_50MHZ,
   input logic             reset,
   bcd_timer_core_if.slave tif
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int AW = $clog2(ALARM_CYCLES + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES - 1);

   localparam int B_START = 0;
   localparam int B_STOP  = 1;
   localparam int B_DEL   = 2;
   localparam int B_INCS  = 3;
   localparam int B_INCM  = 4;
   localparam int NBTN    = 5;

   logic [NBTN-1:0] btn_lvl;
   logic [NBTN-1:0] btn_reg;
   logic [NBTN-1:0] btn_prev_reg;
   logic [NBTN-1:0] btn_ev;

   timer_state_t  state_reg;
   timer_state_t  state_next;
   logic [PW-1:0] presc_reg;
   logic [AW-1:0] alarm_cnt_reg;
   logic          mode_down_reg;
   logic          running_reg;
   logic          finish_reg;
   logic          alarm_reg;

   mmss_t value;
   logic  next_zero;
   logic  next_max;

   logic tick, editable, legal, start_ok, stop_done, load_zero;
   logic inc_sec_en, inc_min_en, tick_up_en, tick_down_en, hit_terminal, finish_set;

   assign btn_lvl = {tif.incrementMinutes, tif.incrementSeconds, tif.delete, tif.stop, tif.start};

   for (genvar gi = 0; gi < NBTN; gi++) begin : g_edge
      assign btn_ev[gi] = btn_reg[gi] & ~btn_prev_reg[gi];
   end

   assign tick      = (state_reg == ST_RUN) && (presc_reg == PRESC_LAST);
   assign editable  = (state_reg == ST_IDLE) || (state_reg == ST_SET) || (state_reg == ST_PAUSE);
   assign legal     = editable || (state_reg == ST_RUN) || (state_reg == ST_DONE);
   // From IDLE (00:00) only an up count makes sense to start.
   assign start_ok  = btn_ev[B_START] && !btn_ev[B_DEL] &&
                      ((state_reg == ST_SET) || (state_reg == ST_PAUSE) ||
                       (state_reg == ST_IDLE && !tif.mode_down));
   assign stop_done = btn_ev[B_STOP] && (state_reg == ST_DONE);
   assign load_zero = !legal || btn_ev[B_DEL] || stop_done;

   assign inc_sec_en   = editable && btn_ev[B_INCS] && !btn_ev[B_DEL] && !start_ok;
   assign inc_min_en   = editable && btn_ev[B_INCM] && !btn_ev[B_DEL] && !start_ok;
   assign tick_down_en = tick && !btn_ev[B_DEL] && mode_down_reg;
   assign tick_up_en   = tick && !btn_ev[B_DEL] && !mode_down_reg;
   assign hit_terminal = mode_down_reg ? next_zero : next_max;

   bcd_mmss_counter #(
      .MAX_MIN (MAX_MIN)
   ) u_counter (
      .CLK_50MHZ (CLK_50MHZ),
      .reset     (reset),
      .load_zero (load_zero),
      .inc_sec   (inc_sec_en),
      .inc_min   (inc_min_en),
      .tick_up   (tick_up_en),
      .tick_down (tick_down_en),
      .value     (value),
      .is_zero   (next_zero),
      .is_max    (next_max)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_SET: begin
            if (start_ok)
               state_next = ST_RUN;
            else if (inc_sec_en || inc_min_en)
               state_next = next_zero ? ST_IDLE : ST_SET;
         end
         ST_PAUSE: begin
            if (start_ok)
               state_next = ST_RUN;
         end
         ST_RUN: begin
            // A tick that reaches the terminal value beats a coincident stop.
            if (tick && hit_terminal)
               state_next = ST_DONE;
            else if (btn_ev[B_STOP])
               state_next = ST_PAUSE;
         end
         ST_DONE: begin
            if (btn_ev[B_STOP])
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (btn_ev[B_DEL])
         state_next = ST_IDLE;
   end

   assign finish_set = (state_reg == ST_RUN) && (state_next == ST_DONE);

   always_ff @(posedge CLK_50MHZ) begin
      if (reset) begin
         btn_reg       <= '0;
         btn_prev_reg  <= '0;
         state_reg     <= ST_IDLE;
         presc_reg     <= '0;
         alarm_cnt_reg <= '0;
         mode_down_reg <= 1'b1;
         running_reg   <= 1'b0;
         finish_reg    <= 1'b0;
         alarm_reg     <= 1'b0;
      end else begin
         btn_reg      <= btn_lvl;
         btn_prev_reg <= btn_reg;
         state_reg    <= state_next;
         running_reg  <= (state_next == ST_RUN);
         finish_reg   <= finish_set;

         if (start_ok)
            mode_down_reg <= tif.mode_down;

         // Outside RUN the prescaler holds; every resume starts a fresh second.
         if (btn_ev[B_DEL] || start_ok)
            presc_reg <= '0;
         else if (state_reg == ST_RUN)
            presc_reg <= tick ? '0 : presc_reg + 1'b1;

         if (btn_ev[B_DEL] || stop_done) begin
            alarm_reg     <= 1'b0;
            alarm_cnt_reg <= '0;
         end else if (finish_set) begin
            alarm_reg     <= 1'b1;
            alarm_cnt_reg <= ALARM_LOAD;
         end else if (alarm_reg) begin
            if (alarm_cnt_reg == '0)
               alarm_reg <= 1'b0;
            else
               alarm_cnt_reg <= alarm_cnt_reg - 1'b1;
         end
      end
   end

   assign tif.mDecimal    = value.m_dec;
   assign tif.mUnit       = value.m_unit;
   assign tif.sDecimal    = value.s_dec;
   assign tif.sUnit       = value.s_unit;
   assign tif.actualState = state_reg;
   assign tif.running     = running_reg;
   assign tif.finish      = finish_reg;
   assign tif.alarm       = alarm_reg;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Directed bench for bcd_timer_core (CLK_DIV=4, MAX_MIN=2, ALARM_CYCLES=3) with an expectation queue.
module tb_bcd_timer_core;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SET   = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [4:0] B_START = 5'b00001;
   localparam logic [4:0] B_STOP  = 5'b00010;
   localparam logic [4:0] B_DEL   = 5'b00100;
   localparam logic [4:0] B_INCS  = 5'b01000;
   localparam logic [4:0] B_INCM  = 5'b10000;

   logic clk = 1'b0;
   logic reset;

   bcd_timer_core_if tif ();

   bcd_timer_core #(
      .CLK_DIV      (4),
      .MAX_MIN      (2),
      .ALARM_CYCLES (3)
   ) dut (
      .CLK_50MHZ (clk),
      .reset     (reset),
      .tif       (tif)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [15:0] digits;
      logic [2:0]  st;
   } exp_t;

   exp_t sb[$];
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests_run++;
      assert (obs === exp_v) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input logic [4:0] m);
      tif.start            = m[0];
      tif.stop             = m[1];
      tif.delete           = m[2];
      tif.incrementSeconds = m[3];
      tif.incrementMinutes = m[4];
   endtask

   task automatic hold(input logic [4:0] m, input int n);
      set_btns(m);
      step(n);
      set_btns(5'b0);
      step(1);
   endtask

   task automatic press(input logic [4:0] m);
      hold(m, 1);
   endtask

   task automatic sb_push(input string tag, input logic [15:0] digits, input logic [2:0] st);
      exp_t e;
      e.tag    = tag;
      e.digits = digits;
      e.st     = st;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      logic [15:0] obs;
      if (sb.size() == 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL sb_empty: observed no pending entry, expected one");
         return;
      end
      e   = sb.pop_front();
      obs = {tif.mDecimal, tif.mUnit, tif.sDecimal, tif.sUnit};
      chk({e.tag, "_digits"}, 32'(obs), 32'(e.digits));
      chk({e.tag, "_state"}, 32'(tif.actualState), 32'(e.st));
      chk({e.tag, "_running"}, 32'(tif.running), (e.st == S_RUN) ? 32'd1 : 32'd0);
      $display("[TB] %s: %h state %0d running %0b", e.tag, obs, tif.actualState, tif.running);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      set_btns(5'b0);
      tif.mode_down = 1'b1;
      step(2);
      sb_push("reset", 16'h0000, S_IDLE);
      sb_check();
      chk("reset_finish", 32'(tif.finish), 32'd0);
      chk("reset_alarm", 32'(tif.alarm), 32'd0);
      reset = 1'b0;
      step(1);

      // 00:03 down to DONE, finish pulse and 3-cycle alarm
      for (int i = 1; i <= 3; i++) begin
         sb_push($sformatf("inc_sec%0d", i), 16'(i), S_SET);
         press(B_INCS);
         sb_check();
      end
      sb_push("start_down", 16'h0003, S_RUN);
      press(B_START);
      sb_check();
      step(4);
      sb_push("tick1", 16'h0002, S_RUN);
      sb_check();
      step(8);
      sb_push("done_down", 16'h0000, S_DONE);
      sb_check();
      chk("finish_pulse", 32'(tif.finish), 32'd1);
      chk("alarm_rise", 32'(tif.alarm), 32'd1);
      step(1);
      chk("finish_low", 32'(tif.finish), 32'd0);
      chk("alarm_c2", 32'(tif.alarm), 32'd1);
      step(1);
      chk("alarm_c3", 32'(tif.alarm), 32'd1);
      step(1);
      chk("alarm_fall", 32'(tif.alarm), 32'd0);
      sb_push("done_hold", 16'h0000, S_DONE);
      sb_check();

      // 01:00 down: borrow, pause, edit in pause, resume timing
      sb_push("delete1", 16'h0000, S_IDLE);
      press(B_DEL);
      sb_check();
      sb_push("inc_min1", 16'h0100, S_SET);
      press(B_INCM);
      sb_check();
      sb_push("start_0100", 16'h0100, S_RUN);
      press(B_START);
      sb_check();
      step(4);
      sb_push("borrow", 16'h0059, S_RUN);
      sb_check();
      sb_push("stop_pause", 16'h0059, S_PAUSE);
      press(B_STOP);
      sb_check();
      sb_push("pause_incm", 16'h0159, S_PAUSE);
      press(B_INCM);
      sb_check();
      sb_push("resume", 16'h0159, S_RUN);
      press(B_START);
      sb_check();
      step(3);
      sb_push("resume_c3", 16'h0159, S_RUN);
      sb_check();
      step(1);
      sb_push("resume_tick", 16'h0158, S_RUN);
      sb_check();

      // up count from IDLE to 02:59
      sb_push("delete2", 16'h0000, S_IDLE);
      press(B_DEL);
      sb_check();
      tif.mode_down = 1'b0;
      sb_push("start_up", 16'h0000, S_RUN);
      press(B_START);
      sb_check();
      step(236);
      sb_push("up_0059", 16'h0059, S_RUN);
      sb_check();
      step(4);
      sb_push("up_carry", 16'h0100, S_RUN);
      sb_check();
      step(476);
      sb_push("up_done", 16'h0259, S_DONE);
      sb_check();
      chk("up_finish", 32'(tif.finish), 32'd1);
      sb_push("done_stop", 16'h0000, S_IDLE);
      press(B_STOP);
      sb_check();
      chk("done_stop_alarm", 32'(tif.alarm), 32'd0);

      // held buttons give one event each
      sb_push("held_start", 16'h0002, S_RUN);
      hold(B_START, 10);
      sb_check();
      step(3);
      sb_push("held_start_t3", 16'h0003, S_RUN);
      sb_check();
      sb_push("stop2", 16'h0003, S_PAUSE);
      press(B_STOP);
      sb_check();
      sb_push("held_incs", 16'h0004, S_PAUSE);
      hold(B_INCS, 10);
      sb_check();
      sb_push("resume2", 16'h0004, S_RUN);
      press(B_START);
      sb_check();
      sb_push("del_stop", 16'h0000, S_IDLE);
      press(B_DEL | B_STOP);
      sb_check();

      // minutes wrap MAX_MIN -> 00 re-selects IDLE
      sb_push("minwrap1", 16'h0100, S_SET);
      press(B_INCM);
      sb_check();
      sb_push("minwrap2", 16'h0200, S_SET);
      press(B_INCM);
      sb_check();
      sb_push("minwrap3", 16'h0000, S_IDLE);
      press(B_INCM);
      sb_check();

      // tick and stop together at 00:01 down: DONE wins
      tif.mode_down = 1'b1;
      sb_push("set_0001", 16'h0001, S_SET);
      press(B_INCS);
      sb_check();
      sb_push("start_0001", 16'h0001, S_RUN);
      press(B_START);
      sb_check();
      step(2);
      set_btns(B_STOP);
      step(1);
      set_btns(5'b0);
      step(1);
      sb_push("tick_stop", 16'h0000, S_DONE);
      sb_check();
      chk("tick_stop_finish", 32'(tif.finish), 32'd1);

      // reset mid-RUN
      sb_push("delete3", 16'h0000, S_IDLE);
      press(B_DEL);
      sb_check();
      tif.mode_down = 1'b0;
      sb_push("start_up2", 16'h0000, S_RUN);
      press(B_START);
      sb_check();
      step(5);
      sb_push("up2_tick", 16'h0001, S_RUN);
      sb_check();
      reset = 1'b1;
      step(1);
      sb_push("mid_reset", 16'h0000, S_IDLE);
      sb_check();
      chk("mid_reset_alarm", 32'(tif.alarm), 32'd0);
      chk("mid_reset_finish", 32'(tif.finish), 32'd0);
      reset = 1'b0;
      step(1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
